pipelined_adder: RTL
====================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined add/subtract unit. WIDTH-bit operands are split into BLOCK_W-bit chunks.
//  Stage k adds chunk k, consuming the carry registered by stage k-1.
//  Throughput: one operation per clock. Valid/ready flow control on both sides.
//  Flags: carry, signed overflow, zero. Sits in the ALU datapath where the 4-bit ripple block is too narrow/slow.
// PARAMETERS
//  WIDTH    16  operand/result width; must be a multiple of BLOCK_W
//  BLOCK_W   4  bits added per pipeline stage; STAGES = WIDTH/BLOCK_W (>=1)
// PORTS
//  i_clk    in   1      clock, all state on rising edge
//  i_rst    in   1      synchronous reset, active-high
//  i_valid  in   1      input operation valid
//  o_ready  out  1      unit accepts input this cycle
//  i_a      in   WIDTH  operand A
//  i_b      in   WIDTH  operand B
//  i_cin    in   1      carry in (borrow in when i_sub=1)
//  i_sub    in   1      0: A+B+cin   1: A-B-cin
//  o_valid  out  1      result valid
//  i_ready  in   1      downstream accepts result
//  o_sum    out  WIDTH  result
//  o_cout   out  1      carry out of MSB (subtract: 1 = no borrow)
//  o_ovf    out  1      two's-complement signed overflow
//  o_zero   out  1      o_sum == 0
// BEHAVIOUR
//  - Reset: all stage valid bits cleared; o_valid=0, o_sum=0, o_cout=0, o_ovf=0, o_zero=0.
//    o_ready=0 while i_rst=1. In-flight operations are discarded; inputs are ignored in the reset cycle.
//  - Advance: adv = ~o_valid | i_ready. o_ready = adv & ~i_rst.
//    This is a combinational i_ready->o_ready path; it is intentional and documented.
//  - Accept: an input transfers when i_valid & o_ready. When adv=1, every stage register shifts one place.
//    When adv=0, all stage registers hold and o_* stay stable.
//  - Subtract: the B operand is replaced by ~i_b. Stage-0 carry = i_sub ? ~i_cin : i_cin.
//  - Stage k (0..STAGES-1) computes chunk k plus the carry registered by stage k-1 (stage 0: the input carry).
//    Its sum chunk and carry are registered.
//  - Operand skew: chunk k of A and B is delayed by k register levels.
//    Sum chunk k is delayed by STAGES-1-k levels, so all chunks reach the output aligned.
//    Skew registers move only on adv.
//  - Latency: STAGES cycles from accept to o_valid when no stall occurs. STAGES=1 gives latency 1.
//  - Stage valid bits shift with data. Bubbles (i_valid=0 while adv=1) travel through as invalid slots.
//    Bubbles are not collapsed.
//  - Output hold: o_valid stays high until the cycle i_ready=1. If a new result follows, it appears the next cycle.
//    Back-to-back results with i_ready held at 1 need no idle cycles.
//  - Flags are computed in the final stage from final-chunk data, registered alongside o_sum.
//    o_ovf = carry into MSB XOR carry out of MSB (XOR taken before any saturation).
//    o_zero is evaluated on the value actually driven on o_sum.
//  - All arithmetic is modulo 2^WIDTH; there is no width growth.
//  - Simultaneous accept and drain in the same cycle is legal; occupancy stays constant.
// CONFIGURATION
//  - Macro PIPELINED_ADDER_SAT_EN defined:
//    on o_ovf=1, o_sum saturates to the signed limit.
//    Positive overflow gives 0111..1; negative overflow gives 1000..0 (sign taken from operand-A MSB).
//    o_ovf still reports the overflow; o_cout is unaffected.
//  - Macro not defined: o_sum always wraps. No saturation logic is generated.
// TESTING  (WIDTH=16, BLOCK_W=4, STAGES=4)
//  - Reset then one add, i_ready=1: A=0x1234, B=0x0FFF, cin=0.
//    -> 4 cycles later o_sum=0x2233, cout=0, ovf=0, zero=0.
//  - Full carry ripple across every stage: A=0xFFFF, B=0x0001.
//    -> o_sum=0x0000, cout=1, zero=1, ovf=0.
//  - Subtract: sub=1, A=0x0005, B=0x0007, cin=0.
//    -> o_sum=0xFFFE, cout=0 (borrow), ovf=0.
//  - Signed overflow: A=0x7FFF, B=0x0001.
//    -> ovf=1; o_sum=0x8000 without the macro, 0x7FFF with PIPELINED_ADDER_SAT_EN.
//  - Stall: stream 6 ops and drop i_ready for 3 cycles once the first result shows.
//    -> o_sum/o_valid stable; o_ready=0; no result lost or duplicated; order preserved.
//  - Reset asserted with 3 ops in flight.
//    -> next cycle o_valid=0; none of those results ever appear; a new op after reset returns in 4 cycles.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH-bit operands processed BLOCK_W bits per stage, valid/ready on both sides.
// Optional saturation on signed overflow when PIPELINED_ADDER_SAT_EN is defined.
module pipelined_adder #(
  parameter int WIDTH   = 16,
  parameter int BLOCK_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int STAGES = WIDTH / BLOCK_W;

  logic adv;
  logic ovf_nx;
  logic ovf_q;
  logic zero_q;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv & ~i_rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic [WIDTH-1:0]   sum_in;
    logic [WIDTH-1:0]   sum_nx;
    logic [WIDTH-1:0]   sum_out;
    logic               carry_in;
    logic               valid_in;
    logic [BLOCK_W:0]   chunk;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic               valid_q;

    if (k == 0) begin : g_head
      assign a_in     = i_a;
      assign b_in     = i_sub ? ~i_b : i_b;
      assign carry_in = i_sub ^ i_cin;
      assign valid_in = i_valid & o_ready;
      assign sum_in   = '0;
    end else begin : g_body
      assign a_in     = g_stage[k-1].a_q;
      assign b_in     = g_stage[k-1].b_q;
      assign carry_in = g_stage[k-1].carry_q;
      assign valid_in = g_stage[k-1].valid_q;
      assign sum_in   = g_stage[k-1].sum_q;
    end

    assign chunk = {1'b0, a_in[k*BLOCK_W +: BLOCK_W]}
                 + {1'b0, b_in[k*BLOCK_W +: BLOCK_W]}
                 + {{BLOCK_W{1'b0}}, carry_in};

    always_comb begin
      sum_nx = sum_in;
      sum_nx[k*BLOCK_W +: BLOCK_W] = chunk[BLOCK_W-1:0];
    end

    if (k == STAGES - 1) begin : g_last
      // Same-sign operands giving an opposite-sign result is exactly cin(MSB) ^ cout(MSB).
      assign ovf_nx = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum_nx[WIDTH-1] != a_in[WIDTH-1]);
`ifdef PIPELINED_ADDER_SAT_EN
      assign sum_out = !ovf_nx ? sum_nx :
                       a_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign sum_out = sum_nx;
`endif
    end else begin : g_mid
      assign sum_out = sum_nx;
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
        a_q     <= '0;
        b_q     <= '0;
      end else if (adv) begin
        valid_q <= valid_in;
        carry_q <= chunk[BLOCK_W];
        sum_q   <= sum_out;
        a_q     <= a_in;
        b_q     <= b_in;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= ovf_nx;
      zero_q <= (g_stage[STAGES-1].sum_out == '0);
    end
  end

  assign o_valid = g_stage[STAGES-1].valid_q;
  assign o_sum   = g_stage[STAGES-1].sum_q;
  assign o_cout  = g_stage[STAGES-1].carry_q;
  assign o_ovf   = ovf_q;
  assign o_zero  = zero_q;

endmodule
